irrigation_demand_fsm: RTL and testbench
========================================

Name: irrigation_demand_fsm

Overview:
- First-stage decision FSM of the automatic irrigation controller. It sits directly upstream of the irrigation-mode FSM.
- Samples the soil-humidity and water-tank level sensors, debounces them, and applies humidity hysteresis and a minimum irrigation on-time.
- Produces the registered irrigation request c_out, which drives the downstream stage's cIn input.
- Also drives the tank inlet (refill) valve and a fault alarm.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive qualified cycles required before entering IRRIGATE or leaving FAULT (>=1).
- MIN_ON_CYCLES, 16, minimum cycles c_out stays high before a "wet" reading may end irrigation.
- CNT_W, 8, counter width; must hold max(DEBOUNCE_CYCLES, MIN_ON_CYCLES, MAX_ON_CYCLES).
- MAX_ON_CYCLES, 200, irrigation timeout; used only with IRRIG_MAX_ON_TIMEOUT_EN.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  system on switch (asynchronous source).
- soil_level  in  2  thermometer humidity code: 00 dry, 01 moist, 11 wet; 10 is invalid.
- tank_level  in  3  thermometer tank code: 000 empty, 001 low, 011 mid, 111 full; any other value is invalid.
- c_out  out  1  irrigation request to the downstream FSM (cIn).
- inlet_valve  out  1  tank refill valve open.
- alarm  out  1  fault indicator.
- state_out  out  2  current state: IDLE=00, DEBOUNCE=01, IRRIGATE=10, FAULT=11.

Behaviour:
- Interface: one clock, clock; reset is asynchronous and active-low, reset_n.
- Reset: state IDLE, counters 0, synchronizers 0. c_out=0, inlet_valve=0, alarm=0, state_out=00. Reset asserted mid-operation aborts immediately with the same values.
- Input synchronization:
  - enable, soil_level and tank_level each pass through a 2-flop synchronizer.
  - All decisions below use the synchronized values.
- Derived conditions:
  - valid = soil code valid AND tank code valid.
  - dry = (soil==00).
  - wet = (soil==11).
  - usable = (tank != 000).
  - go = valid & enable & dry & usable.
- IDLE: go -> DEBOUNCE with cnt=0. Invalid code -> FAULT.
- DEBOUNCE:
  - go with cnt==DEBOUNCE_CYCLES-1 -> IRRIGATE, on_cnt=0.
  - go otherwise -> cnt+1.
  - !go -> IDLE, except invalid code -> FAULT.
- IRRIGATE: on_cnt increments, saturating at MIN_ON_CYCLES. Exits are evaluated in priority order:
  1. invalid code or tank==000 -> FAULT immediately; overrides min on-time.
  2. !enable -> IDLE immediately.
  3. wet AND on_cnt>=MIN_ON_CYCLES -> IDLE.
  - Moist (01) holds IRRIGATE; this is the hysteresis band.
- FAULT:
  - alarm=1, c_out=0. enable is ignored.
  - cnt counts cycles with valid AND tank in {011,111}; any other cycle clears cnt.
  - cnt==DEBOUNCE_CYCLES-1 with the condition true -> IDLE.
- Outputs are registered and change on the same edge as the state:
  - c_out=1 only in IRRIGATE.
  - alarm=1 only in FAULT.
  - state_out mirrors the state.
- Latency: stable dry/usable/enabled inputs raise c_out on the (3+DEBOUNCE_CYCLES)th rising edge after the inputs settle (7 edges at the default).
- Inlet valve (independent of the FSM, registered):
  - Set when the tank code is 000 or 001.
  - Cleared when the tank code is 111.
  - Held at 011.
  - Forced to 0 while the tank code is invalid.
  - Active in every state, including FAULT.

Optional Feature:
- Macro: IRRIG_MAX_ON_TIMEOUT_EN.
- Defined: a separate timer counts cycles in IRRIGATE. Reaching MAX_ON_CYCLES -> FAULT (a sensor stuck-dry guard), at priority just below invalid/empty.
- Undefined: no timer, and irrigation may last indefinitely.

Decomposition:
- Package irrigation_pkg holds:
  - the state encoding constants (IDLE, DEBOUNCE, IRRIGATE, FAULT);
  - the soil codes (SOIL_DRY, SOIL_MOIST, SOIL_WET);
  - the tank codes (TANK_EMPTY, TANK_LOW, TANK_MID, TANK_FULL).
- One natural sub-module: sync_2ff, a parameterized-width two-flop synchronizer with async active-low reset. It is instantiated three times (enable, soil, tank).

Test Plan:
- Reset, then enable=1, soil=00, tank=111 held -> state_out 00->01->10; c_out rises on the 7th edge; alarm=0; inlet_valve=0.
- In IRRIGATE, soil=11 at on_cnt=5 -> c_out stays 1 until on_cnt reaches 16, then IDLE. Soil=01 at any time -> c_out stays 1.
- In DEBOUNCE, soil pulses to 01 for 1 cycle at cnt=2 -> return to IDLE; a clean 4-cycle dry period is then required; c_out never glitches high.
- In IRRIGATE, tank falls to 000 -> FAULT on the next edge after sync; c_out=0, alarm=1, inlet_valve=1. Tank then goes 011 for 3 cycles, 001 for 1 cycle, then 011 for 4 cycles -> IDLE only after the final 4.
- soil=10 or tank=101 from IDLE -> FAULT, inlet_valve=0. Assert reset_n=0 mid-FAULT -> all outputs 0 asynchronously.
- With IRRIG_MAX_ON_TIMEOUT_EN and MAX_ON_CYCLES=20: soil held 00 -> FAULT after 20 IRRIGATE cycles. Without the macro: still IRRIGATE at 1000 cycles.

Source files
------------

// File: rtl/irrigation_pkg.sv
// Shared encodings for the irrigation demand stage: FSM states, soil and tank
// thermometer codes, and code-validity helpers.
package irrigation_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DEBOUNCE = 2'b01,
    IRRIGATE = 2'b10,
    FAULT    = 2'b11
  } state_t;

  localparam logic [1:0] SOIL_DRY   = 2'b00;
  localparam logic [1:0] SOIL_MOIST = 2'b01;
  localparam logic [1:0] SOIL_WET   = 2'b11;

  localparam logic [2:0] TANK_EMPTY = 3'b000;
  localparam logic [2:0] TANK_LOW   = 3'b001;
  localparam logic [2:0] TANK_MID   = 3'b011;
  localparam logic [2:0] TANK_FULL  = 3'b111;

  function automatic logic soil_valid(input logic [1:0] s);
    return s inside {SOIL_DRY, SOIL_MOIST, SOIL_WET};
  endfunction

  function automatic logic tank_valid(input logic [2:0] t);
    return t inside {TANK_EMPTY, TANK_LOW, TANK_MID, TANK_FULL};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Parameterized-width two-flop synchronizer with asynchronous active-low reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_reg <= '0;
      q        <= '0;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/irrigation_demand_fsm.sv
// Irrigation demand FSM: debounced soil/tank decisions, hysteresis, minimum on-time,
// refill valve and fault alarm. IRRIG_MAX_ON_TIMEOUT_EN adds an irrigation timeout.
module irrigation_demand_fsm
  import irrigation_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_ON_CYCLES   = 16,
  parameter int CNT_W           = 8,
  parameter int MAX_ON_CYCLES   = 200
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] soil_level,
  input  logic [2:0] tank_level,
  output logic       c_out,
  output logic       inlet_valve,
  output logic       alarm,
  output logic [1:0] state_out
);

  if (DEBOUNCE_CYCLES < 1 || (2 ** CNT_W) <= DEBOUNCE_CYCLES ||
      (2 ** CNT_W) <= MIN_ON_CYCLES || (2 ** CNT_W) <= MAX_ON_CYCLES) begin : g_bad_cfg
    $error("irrigation_demand_fsm: CNT_W too narrow or DEBOUNCE_CYCLES < 1");
  end

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_ON   = CNT_W'(MIN_ON_CYCLES);

  logic       enable_s;
  logic [1:0] soil_s;
  logic [2:0] tank_s;

  sync_2ff #(.WIDTH(1)) u_sync_enable (.clock(clock), .reset_n(reset_n), .d(enable),     .q(enable_s));
  sync_2ff #(.WIDTH(2)) u_sync_soil   (.clock(clock), .reset_n(reset_n), .d(soil_level), .q(soil_s));
  sync_2ff #(.WIDTH(3)) u_sync_tank   (.clock(clock), .reset_n(reset_n), .d(tank_level), .q(tank_s));

  logic valid, dry, wet, usable, go, refill_ok;

  assign valid     = soil_valid(soil_s) && tank_valid(tank_s);
  assign dry       = (soil_s == SOIL_DRY);
  assign wet       = (soil_s == SOIL_WET);
  assign usable    = (tank_s != TANK_EMPTY);
  assign go        = valid && enable_s && dry && usable;
  assign refill_ok = valid && (tank_s == TANK_MID || tank_s == TANK_FULL);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] on_cnt, on_cnt_next;

`ifdef IRRIG_MAX_ON_TIMEOUT_EN
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_ON_CYCLES - 1);
  logic [CNT_W-1:0] tmr, tmr_next;
  logic             timeout;

  assign timeout  = (tmr == MAX_LAST);
  assign tmr_next = (state == IRRIGATE) ? tmr + CNT_W'(1) : '0;
`else
  logic timeout;

  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    on_cnt_next = on_cnt;
    case (state)
      IDLE: begin
        if (!valid) begin
          state_next = FAULT;
          cnt_next   = '0;
        end else if (go) begin
          state_next = DEBOUNCE;
          cnt_next   = '0;
        end
      end
      DEBOUNCE: begin
        if (go) begin
          if (cnt == DEB_LAST) begin
            state_next  = IRRIGATE;
            on_cnt_next = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end else begin
          state_next = valid ? IDLE : FAULT;
          cnt_next   = '0;
        end
      end
      IRRIGATE: begin
        if (on_cnt < MIN_ON) on_cnt_next = on_cnt + CNT_W'(1);
        // Sensor faults and an empty tank override the minimum on-time.
        if (!valid || !usable || timeout) begin
          state_next = FAULT;
          cnt_next   = '0;
        end else if (!enable_s) begin
          state_next = IDLE;
        end else if (wet && on_cnt >= MIN_ON) begin
          state_next = IDLE;
        end
      end
      FAULT: begin
        if (refill_ok) begin
          if (cnt == DEB_LAST) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end else begin
          cnt_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      on_cnt <= '0;
      c_out  <= 1'b0;
      alarm  <= 1'b0;
`ifdef IRRIG_MAX_ON_TIMEOUT_EN
      tmr    <= '0;
`endif
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      on_cnt <= on_cnt_next;
      c_out  <= (state_next == IRRIGATE);
      alarm  <= (state_next == FAULT);
`ifdef IRRIG_MAX_ON_TIMEOUT_EN
      tmr    <= tmr_next;
`endif
    end
  end

  // Refill valve follows the tank code alone; 011 is the hysteresis band.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inlet_valve <= 1'b0;
    end else if (!tank_valid(tank_s)) begin
      inlet_valve <= 1'b0;
    end else if (tank_s == TANK_EMPTY || tank_s == TANK_LOW) begin
      inlet_valve <= 1'b1;
    end else if (tank_s == TANK_FULL) begin
      inlet_valve <= 1'b0;
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_irrigation_demand_fsm.sv
// Self-checking bench for irrigation_demand_fsm: per-cycle model comparison plus
// hand-computed literal checkpoints. Honours IRRIG_MAX_ON_TIMEOUT_EN if defined.
module tb_irrigation_demand_fsm;

  localparam int DEB    = 4;
  localparam int MIN_ON = 16;
  localparam int MAX_ON = 200;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] soil_level = 2'b00;
  logic [2:0] tank_level = 3'b000;
  logic       c_out, inlet_valve, alarm;
  logic [1:0] state_out;

  int tests = 0;
  int fails = 0;

  irrigation_demand_fsm dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .soil_level(soil_level), .tank_level(tank_level),
    .c_out(c_out), .inlet_valve(inlet_valve), .alarm(alarm), .state_out(state_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: decisions see the raw inputs sampled two edges earlier.
  localparam int M_IDLE = 0, M_DEB = 1, M_IRR = 2, M_FAULT = 3;
  int         m_state = M_IDLE;
  int         m_run = 0;
  int         m_on = 0;
  int         m_tmr = 0;
  bit         m_valve = 0;
  logic [1:0] soil_h[2] = '{2'b00, 2'b00};
  logic [2:0] tank_h[2] = '{3'b000, 3'b000};
  logic       en_h[2]   = '{1'b0, 1'b0};

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_state = M_IDLE; m_run = 0; m_on = 0; m_tmr = 0; m_valve = 0;
      soil_h = '{2'b00, 2'b00}; tank_h = '{3'b000, 3'b000}; en_h = '{1'b0, 1'b0};
    end else begin
      logic [1:0] s;
      logic [2:0] t;
      bit sv, tv, ok, go, timed_out;
      int on_before;
      s  = soil_h[1];
      t  = tank_h[1];
      sv = (s != 2'b10);
      tv = (t == 3'd0 || t == 3'd1 || t == 3'd3 || t == 3'd7);
      ok = sv && tv;
      go = ok && en_h[1] && (s == 2'b00) && (t != 3'd0);
      timed_out = 0;
`ifdef IRRIG_MAX_ON_TIMEOUT_EN
      timed_out = (m_state == M_IRR) && (m_tmr + 1 >= MAX_ON);
`endif
      on_before = m_on;
      case (m_state)
        M_IDLE:  if (!ok) begin m_state = M_FAULT; m_run = 0; end
                 else if (go) begin m_state = M_DEB; m_run = 1; end
        M_DEB:   if (!go) begin m_state = ok ? M_IDLE : M_FAULT; m_run = 0; end
                 else if (m_run >= DEB) begin m_state = M_IRR; m_on = 0; m_tmr = 0; end
                 else m_run++;
        M_IRR: begin
          m_on  = (m_on + 1 > MIN_ON) ? MIN_ON : m_on + 1;
          m_tmr++;
          if (!ok || t == 3'd0 || timed_out) begin m_state = M_FAULT; m_run = 0; end
          else if (!en_h[1]) m_state = M_IDLE;
          else if (s == 2'b11 && on_before >= MIN_ON) m_state = M_IDLE;
        end
        default: begin
          // m_run = length of the current run of healthy refill readings
          if (ok && (t == 3'd3 || t == 3'd7)) m_run++;
          else m_run = 0;
          if (m_run >= DEB) begin m_state = M_IDLE; m_run = 0; end
        end
      endcase
      if (!tv) m_valve = 0;
      else if (t <= 3'd1) m_valve = 1;
      else if (t == 3'd7) m_valve = 0;
      soil_h[1] = soil_h[0]; soil_h[0] = soil_level;
      tank_h[1] = tank_h[0]; tank_h[0] = tank_level;
      en_h[1]   = en_h[0];   en_h[0]   = enable;
    end
  end

  always @(negedge clock) begin
    check("cyc_state", {6'd0, state_out}, 8'(m_state));
    check("cyc_c_out", {7'd0, c_out}, {7'd0, m_state == M_IRR});
    check("cyc_alarm", {7'd0, alarm}, {7'd0, m_state == M_FAULT});
    check("cyc_valve", {7'd0, inlet_valve}, {7'd0, m_valve});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic lit(input string name, input logic [1:0] st, input logic c, input logic a);
    check({name, "_state"}, {6'd0, state_out}, {6'd0, st});
    check({name, "_c_out"}, {7'd0, c_out}, {7'd0, c});
    check({name, "_alarm"}, {7'd0, alarm}, {7'd0, a});
  endtask

  initial begin
    enable = 1'b1; soil_level = 2'b00; tank_level = 3'b111;
    tick(2);
    lit("reset", 2'b00, 1'b0, 1'b0);
    check("reset_valve", {7'd0, inlet_valve}, 8'd0);
    reset_n = 1'b1;

    // Latency: c_out rises on the 7th edge after release
    tick(2); lit("lat_e2", 2'b00, 1'b0, 1'b0);
    tick(1); lit("lat_e3", 2'b01, 1'b0, 1'b0);
    tick(3); lit("lat_e6", 2'b01, 1'b0, 1'b0);
    tick(1); lit("lat_e7", 2'b10, 1'b1, 1'b0);
    check("lat_valve", {7'd0, inlet_valve}, 8'd0);

    // Wet early: held until on_cnt reaches MIN_ON
    tick(4); soil_level = 2'b11;
    tick(12); lit("minon_hold", 2'b10, 1'b1, 1'b0);
    tick(1);  lit("minon_exit", 2'b00, 1'b0, 1'b0);

    // Moist band holds IRRIGATE
    soil_level = 2'b00;
    tick(7); lit("moist_enter", 2'b10, 1'b1, 1'b0);
    soil_level = 2'b01;
    tick(40); lit("moist_hold", 2'b10, 1'b1, 1'b0);
    soil_level = 2'b11;
    tick(2); lit("moist_wet_a", 2'b10, 1'b1, 1'b0);
    tick(1); lit("moist_wet_b", 2'b00, 1'b0, 1'b0);

    // Debounce glitch at cnt=2 restarts the dry qualification
    soil_level = 2'b00;
    tick(3); lit("glitch_deb", 2'b01, 1'b0, 1'b0);
    soil_level = 2'b01;
    tick(1); soil_level = 2'b00;
    tick(2); lit("glitch_idle", 2'b00, 1'b0, 1'b0);
    tick(1); lit("glitch_redeb", 2'b01, 1'b0, 1'b0);
    tick(3); lit("glitch_wait", 2'b01, 1'b0, 1'b0);
    tick(1); lit("glitch_irr", 2'b10, 1'b1, 1'b0);

    // Enable drop exits IRRIGATE before min on-time
    enable = 1'b0;
    tick(2); lit("en_hold", 2'b10, 1'b1, 1'b0);
    tick(1); lit("en_idle", 2'b00, 1'b0, 1'b0);
    enable = 1'b1;
    tick(7); lit("en_reirr", 2'b10, 1'b1, 1'b0);

    // Empty tank -> FAULT, then recovery needs 4 consecutive mid readings
    tank_level = 3'b000;
    tick(2); lit("empty_hold", 2'b10, 1'b1, 1'b0);
    tick(1); lit("empty_fault", 2'b11, 1'b0, 1'b1);
    check("empty_valve", {7'd0, inlet_valve}, 8'd1);
    tank_level = 3'b011;
    tick(3); tank_level = 3'b001;
    tick(1); tank_level = 3'b011;
    tick(5); lit("recov_wait", 2'b11, 1'b0, 1'b1);
    tick(1); lit("recov_idle", 2'b00, 1'b0, 1'b0);
    check("recov_valve", {7'd0, inlet_valve}, 8'd1);

    // Invalid codes from IDLE
    enable = 1'b0; tank_level = 3'b111;
    tick(4); lit("inv_idle", 2'b00, 1'b0, 1'b0);
    check("inv_valve_full", {7'd0, inlet_valve}, 8'd0);
    soil_level = 2'b10;
    tick(2); lit("soil_inv_a", 2'b00, 1'b0, 1'b0);
    tick(1); lit("soil_inv_f", 2'b11, 1'b0, 1'b1);
    soil_level = 2'b00; tank_level = 3'b001;
    tick(3); lit("low_fault", 2'b11, 1'b0, 1'b1);
    check("low_valve", {7'd0, inlet_valve}, 8'd1);
    tank_level = 3'b101;
    tick(3); lit("tank_inv_f", 2'b11, 1'b0, 1'b1);
    check("tank_inv_valve", {7'd0, inlet_valve}, 8'd0);
    tank_level = 3'b001;
    tick(3);
    check("pre_rst_valve", {7'd0, inlet_valve}, 8'd1);

    // Asynchronous reset mid-FAULT
    reset_n = 1'b0;
    #1;
    lit("async_rst", 2'b00, 1'b0, 1'b0);
    check("async_rst_valve", {7'd0, inlet_valve}, 8'd0);
    tick(2);
    enable = 1'b1; soil_level = 2'b00; tank_level = 3'b111;
    reset_n = 1'b1;

    // Long stuck-dry hold
    tick(7); lit("long_enter", 2'b10, 1'b1, 1'b0);
    tick(1000);
`ifndef IRRIG_MAX_ON_TIMEOUT_EN
    lit("long_hold", 2'b10, 1'b1, 1'b0);
`endif
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
